reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 35 +++
 rtl/reset_sync.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/reset_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
// Also holds a helper that sizes the shared stage counter.
package reset_seq_pkg;

    localparam int unsigned DEF_N_DOM       = 32'd4;
    localparam int unsigned DEF_MIN_ASSERT  = 32'd16;
    localparam int unsigned DEF_STAGE_DLY   = 32'd8;
    localparam int unsigned DEF_ACK_TIMEOUT = 32'd64;

    typedef enum logic [1:0] {
        ST_STRETCH  = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_HOLD     = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_e;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

    // The counter must represent the largest of the three intervals without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = max3(a, b, c);
        return (m < 32'd2) ? 32'd1 : $clog2(m + 32'd1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after two clock edges.
module reset_sync (
    input  logic clk_i,
    input  logic rst_async_i,
    output logic rst_sync_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage release chain, set asynchronously by the raw reset.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= 1'b0;
            sync_q <= meta_q;
        end
    end

    assign rst_sync_o = sync_q;

endmodule

// File: rtl/sync_2ff.sv
// Multi-bit two-flop synchronizer for independent level signals.
module sync_2ff #(
    parameter int unsigned WIDTH = 32'd1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Both stages are cleared while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOM downstream resets in index order, waiting for each domain's
// acknowledge (or a timeout) plus a fixed hold before releasing the next one.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned N_DOM       = DEF_N_DOM,
    parameter int unsigned MIN_ASSERT  = DEF_MIN_ASSERT,
    parameter int unsigned STAGE_DLY   = DEF_STAGE_DLY,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             sw_rst_req,
    input  logic [N_DOM-1:0] rst_ack,
    output logic [N_DOM-1:0] rst_out,
    output logic             rst_done,
    output logic             timeout_err
);

    localparam int unsigned CNT_W = cnt_width(MIN_ASSERT, STAGE_DLY, ACK_TIMEOUT);
    localparam int unsigned IDX_W = (N_DOM > 32'd1) ? $clog2(N_DOM) : 32'd1;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(MIN_ASSERT - 32'd1);
    localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(STAGE_DLY - 32'd1);
    localparam logic [IDX_W-1:0] IDX_ZERO     = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DOM - 32'd1);
    localparam logic [N_DOM-1:0] ALL_ON       = {N_DOM{1'b1}};
    localparam logic [N_DOM-1:0] ALL_OFF      = {N_DOM{1'b0}};

    logic             rst_int;
    logic [N_DOM-1:0] ack_s;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_DOM-1:0] rst_out_q, rst_out_d;
    logic             rst_done_q, rst_done_d;
    logic             timeout_err_q, timeout_err_d;

    reset_sync u_reset_sync (
        .clk_i       (clk),
        .rst_async_i (rst_async),
        .rst_sync_o  (rst_int)
    );

    sync_2ff #(
        .WIDTH (N_DOM)
    ) u_ack_sync (
        .clk_i (clk),
        .rst_i (rst_int),
        .d_i   (rst_ack),
        .q_o   (ack_s)
    );

    // State, counter and output registers; rst_int asserts them asynchronously.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q       <= ST_STRETCH;
            cnt_q         <= CNT_ZERO;
            idx_q         <= IDX_ZERO;
            rst_out_q     <= ALL_ON;
            rst_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rst_out_q     <= rst_out_d;
            rst_done_q    <= rst_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic. rst_out is a thermometer code (released bits at the
    // bottom), so a left shift releases exactly the next domain.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rst_out_d     = rst_out_q;
        rst_done_d    = rst_done_q;
        timeout_err_d = timeout_err_q;

        if (sw_rst_req) begin
            state_d       = ST_STRETCH;
            cnt_d         = CNT_ZERO;
            idx_d         = IDX_ZERO;
            rst_out_d     = ALL_ON;
            rst_done_d    = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_STRETCH: begin
                    rst_out_d  = ALL_ON;
                    rst_done_d = 1'b0;
                    if (cnt_q == STRETCH_LAST) begin
                        state_d   = ST_WAIT_ACK;
                        cnt_d     = CNT_ZERO;
                        idx_d     = IDX_ZERO;
                        rst_out_d = ALL_ON << 1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_s[idx_q]) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == ACK_LAST) begin
                        state_d       = ST_HOLD;
                        cnt_d         = CNT_ZERO;
                        timeout_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (idx_q == IDX_LAST) begin
                            state_d    = ST_DONE;
                            rst_out_d  = ALL_OFF;
                            rst_done_d = 1'b1;
                        end else begin
                            state_d   = ST_WAIT_ACK;
                            idx_d     = idx_q + IDX_ONE;
                            rst_out_d = rst_out_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    rst_out_d  = ALL_OFF;
                    rst_done_d = 1'b1;
                end
                default: begin
                    state_d    = ST_STRETCH;
                    cnt_d      = CNT_ZERO;
                    idx_d      = IDX_ZERO;
                    rst_out_d  = ALL_ON;
                    rst_done_d = 1'b0;
                end
            endcase
        end
    end

    assign rst_out     = rst_out_q;
    assign rst_done    = rst_done_q;
    assign timeout_err = timeout_err_q;

endmodule
